// File: rtl/sobel_edge_param.sv
// 3x3 Sobel edge processor: luma raster in, one RGB565 word out per pixel (pass, magnitude, threshold, inverted threshold).
// Fixed 3-cycle latency from pix_vld to out_vld; no backpressure, the consumer must accept every out_vld.
module sobel_edge_param #(
   parameter int IMG_W  = 800,
   parameter int IMG_H  = 480,
   parameter int DATA_W = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              frame_start,
   input  logic              pix_vld,
   input  logic [DATA_W-1:0] pix_y,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] threshold,
   output logic              out_vld,
   output logic [15:0]       out_data,
   output logic              out_sof,
   output logic              out_eol
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int GW = DATA_W + 3;
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

   typedef logic [DATA_W-1:0] pix_t;

   function automatic logic signed [GW-1:0] ext(input pix_t v);
      return $signed({3'b000, v});
   endfunction

   function automatic logic [15:0] gray565(input pix_t v);
      return {v[DATA_W-1 -: 5], v[DATA_W-1 -: 6], v[DATA_W-1 -: 5]};
   endfunction

   // frame state
   logic [CW-1:0] col_q, col_d, col_eff;
   logic [RW-1:0] row_q, row_d, row_eff;
   logic [1:0]    mode_q, mode_d;
   pix_t          thr_q, thr_d;

   // line buffers: lb0 holds row r-1, lb1 holds row r-2
   pix_t lb0_q [IMG_W];
   pix_t lb1_q [IMG_W];
   pix_t lb_rd0, lb_rd1;

   // S1: window plus per-pixel sideband
   pix_t       win_q [3][3];
   pix_t       win_d [3][3];
   logic       s1_vld_q, s1_vld_d;
   logic       s1_brd_q, s1_brd_d;
   logic       s1_sof_q, s1_sof_d;
   logic       s1_eol_q, s1_eol_d;
   logic [1:0] s1_mode_q, s1_mode_d;
   pix_t       s1_thr_q, s1_thr_d;

   // S2: gradients
   logic                 s2_vld_q, s2_vld_d;
   logic signed [GW-1:0] s2_gx_q, s2_gx_d;
   logic signed [GW-1:0] s2_gy_q, s2_gy_d;
   pix_t                 s2_ctr_q, s2_ctr_d;
   logic                 s2_brd_q, s2_brd_d;
   logic                 s2_sof_q, s2_sof_d;
   logic                 s2_eol_q, s2_eol_d;
   logic [1:0]           s2_mode_q, s2_mode_d;
   pix_t                 s2_thr_q, s2_thr_d;

   // S3: output register
   logic          out_vld_q, out_vld_d;
   logic [15:0]   out_data_q, out_data_d;
   logic          out_sof_q, out_sof_d;
   logic          out_eol_q, out_eol_d;
   logic [GW-1:0] ax, ay, mag;
   pix_t          sat;
   logic          hit;

   // frame_start clears position before a coincident pixel uses it
   always_comb begin
      col_eff   = frame_start ? '0 : col_q;
      row_eff   = frame_start ? '0 : row_q;
      mode_d    = frame_start ? mode : mode_q;
      thr_d     = frame_start ? threshold : thr_q;
      col_d     = col_eff;
      row_d     = row_eff;
      lb_rd0    = lb0_q[col_eff];
      lb_rd1    = lb1_q[col_eff];
      win_d     = win_q;
      s1_vld_d  = pix_vld;
      s1_brd_d  = s1_brd_q;
      s1_sof_d  = s1_sof_q;
      s1_eol_d  = s1_eol_q;
      s1_mode_d = s1_mode_q;
      s1_thr_d  = s1_thr_q;
      if (pix_vld) begin
         if (col_eff == LAST_COL) begin
            col_d = '0;
            row_d = (row_eff == LAST_ROW) ? '0 : row_eff + RW'(1);
         end else begin
            col_d = col_eff + CW'(1);
         end
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
         end
         win_d[0][2] = lb_rd1;
         win_d[1][2] = lb_rd0;
         win_d[2][2] = pix_y;
         s1_brd_d  = (row_eff < RW'(2)) || (col_eff < CW'(2));
         s1_sof_d  = (row_eff == '0) && (col_eff == '0);
         s1_eol_d  = (col_eff == LAST_COL);
         s1_mode_d = mode_d;
         s1_thr_d  = thr_d;
      end
   end

   always_comb begin
      s2_vld_d  = s1_vld_q;
      s2_gx_d   = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
                - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
      s2_gy_d   = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
                - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
      s2_ctr_d  = s1_brd_q ? '0 : win_q[1][1];
      s2_brd_d  = s1_brd_q;
      s2_sof_d  = s1_sof_q;
      s2_eol_d  = s1_eol_q;
      s2_mode_d = s1_mode_q;
      s2_thr_d  = s1_thr_q;
   end

   // border positions see stale line-buffer data, so the magnitude is forced to 0 there
   always_comb begin
      ax  = s2_gx_q[GW-1] ? $unsigned(-s2_gx_q) : $unsigned(s2_gx_q);
      ay  = s2_gy_q[GW-1] ? $unsigned(-s2_gy_q) : $unsigned(s2_gy_q);
      mag = ax + ay;
      if (s2_brd_q)
         sat = '0;
      else if (|mag[GW-1:DATA_W])
         sat = '1;
      else
         sat = mag[DATA_W-1:0];
      hit = (sat >= s2_thr_q);
      case (s2_mode_q)
         2'd0:    out_data_d = gray565(s2_ctr_q);
         2'd1:    out_data_d = gray565(sat);
         2'd2:    out_data_d = hit ? 16'hFFFF : 16'h0000;
         default: out_data_d = hit ? 16'h0000 : 16'hFFFF;
      endcase
      out_vld_d = s2_vld_q;
      out_sof_d = s2_vld_q & s2_sof_q;
      out_eol_d = s2_vld_q & s2_eol_q;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         col_q      <= '0;
         row_q      <= '0;
         mode_q     <= 2'd1;
         thr_q      <= '0;
         win_q      <= '{default: '0};
         s1_vld_q   <= 1'b0;
         s1_brd_q   <= 1'b1;
         s1_sof_q   <= 1'b0;
         s1_eol_q   <= 1'b0;
         s1_mode_q  <= 2'd1;
         s1_thr_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_gx_q    <= '0;
         s2_gy_q    <= '0;
         s2_ctr_q   <= '0;
         s2_brd_q   <= 1'b1;
         s2_sof_q   <= 1'b0;
         s2_eol_q   <= 1'b0;
         s2_mode_q  <= 2'd1;
         s2_thr_q   <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= 16'h0000;
         out_sof_q  <= 1'b0;
         out_eol_q  <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         mode_q     <= mode_d;
         thr_q      <= thr_d;
         win_q      <= win_d;
         s1_vld_q   <= s1_vld_d;
         s1_brd_q   <= s1_brd_d;
         s1_sof_q   <= s1_sof_d;
         s1_eol_q   <= s1_eol_d;
         s1_mode_q  <= s1_mode_d;
         s1_thr_q   <= s1_thr_d;
         s2_vld_q   <= s2_vld_d;
         s2_gx_q    <= s2_gx_d;
         s2_gy_q    <= s2_gy_d;
         s2_ctr_q   <= s2_ctr_d;
         s2_brd_q   <= s2_brd_d;
         s2_sof_q   <= s2_sof_d;
         s2_eol_q   <= s2_eol_d;
         s2_mode_q  <= s2_mode_d;
         s2_thr_q   <= s2_thr_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_sof_q  <= out_sof_d;
         out_eol_q  <= out_eol_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (pix_vld) begin
         lb0_q[col_eff] <= pix_y;
         lb1_q[col_eff] <= lb_rd0;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_sof  = out_sof_q;
   assign out_eol  = out_eol_q;

endmodule
